// File: rtl/ps2_key_fifo.sv
// rtl/ps2_key_fifo.sv - PS/2 keyboard receiver with scan-code decoder and key FIFO
module ps2_key_fifo #(
  parameter int FILT_LEN    = 8,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        pop,
  output logic [31:0] key_data,
  output logic        key_valid,
  output logic        frame_err,
  output logic        overflow
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN - 1);
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // ---------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------
  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic          data_bit;

  assign data_bit = data_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // The filtered clock follows the synchronised line only after FILT_LEN
  // consecutive disagreeing samples; fall is registered with the flip.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_sync[1] != clk_filt) begin
        if (filt_cnt == FILT_MAX) begin
          clk_filt <= clk_sync[1];
          filt_cnt <= '0;
          fall     <= clk_filt;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          byte_rdy;
  logic [7:0]    byte_val;

  // tcnt holds the number of cycles elapsed since the most recent fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      tcnt      <= '0;
      byte_rdy  <= 1'b0;
      byte_val  <= '0;
      frame_err <= 1'b0;
    end else begin
      byte_rdy  <= 1'b0;
      frame_err <= 1'b0;
      if (fall)
        tcnt <= TW'(1);
      else if (state != IDLE)
        tcnt <= tcnt + 1'b1;
      else
        tcnt <= '0;

      if (state != IDLE && !fall && tcnt == TMAX) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        tcnt      <= '0;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!data_bit) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {data_bit, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7)
              state <= PARITY;
          end
          PARITY: begin
            par_bit <= data_bit;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (data_bit && (^{shreg, par_bit})) begin
              byte_rdy <= 1'b1;
              byte_val <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------
  // Scan-code decoder
  // ---------------------------------------------------------------
  logic       brk;
  logic       ext;
  logic       map_hit;
  logic [4:0] map_code;
  logic       is_prefix;
  logic       push;

  always_comb begin
    map_hit  = 1'b1;
    map_code = 5'h00;
    case (byte_val)
      8'h45: map_code = 5'h00;
      8'h16: map_code = 5'h01;
      8'h1E: map_code = 5'h02;
      8'h26: map_code = 5'h03;
      8'h25: map_code = 5'h04;
      8'h2E: map_code = 5'h05;
      8'h36: map_code = 5'h06;
      8'h3D: map_code = 5'h07;
      8'h3E: map_code = 5'h08;
      8'h46: map_code = 5'h09;
      8'h1C: map_code = 5'h0A;
      8'h32: map_code = 5'h0B;
      8'h21: map_code = 5'h0C;
      8'h23: map_code = 5'h0D;
      8'h24: map_code = 5'h0E;
      8'h2B: map_code = 5'h0F;
      8'h5A: map_code = 5'h10;
      8'h66: map_code = 5'h11;
      default: map_hit = 1'b0;
    endcase
  end

  assign is_prefix = (byte_val == 8'hF0) || (byte_val == 8'hE0);
  assign push      = byte_rdy && !is_prefix && !brk && !ext && map_hit;

  // The byte following a break or extended prefix is swallowed whole.
  always_ff @(posedge clk) begin
    if (rst) begin
      brk <= 1'b0;
      ext <= 1'b0;
    end else if (byte_rdy) begin
      if (byte_val == 8'hF0) begin
        brk <= 1'b1;
      end else if (byte_val == 8'hE0) begin
        ext <= 1'b1;
      end else if (brk || ext) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------
  // Key FIFO
  // ---------------------------------------------------------------
  logic [4:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          do_pop;
  logic          do_push;
  logic [4:0]    head_code;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= map_code;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
      if (do_pop)
        overflow <= 1'b0;
      else if (push && full)
        overflow <= 1'b1;
    end
  end

  assign key_valid = !empty;
  assign head_code = empty ? 5'h00 : mem[rd_ptr];
  assign key_data  = {23'b0, key_valid, 3'b0, head_code};

endmodule
